// File: rtl/vreg_wb_arbiter_if.sv
// Write-back bus bundle for vreg_wb_arbiter: two result producers, the
// register-file write port, and the issue-stage reservation/scoreboard signals.
// The master modport is the producer/issue side; the slave modport is the arbiter.
interface vreg_wb_arbiter_if #(
  parameter int DATA_W = 256,
  parameter int LEN_W  = 4
);
  // Requester 0 (vector ALU)
  logic              req0_valid;
  logic              req0_ready;
  logic [3:0]        req0_addr;
  logic [LEN_W-1:0]  req0_len;
  logic [DATA_W-1:0] req0_data;

  // Requester 1 (vector load unit)
  logic              req1_valid;
  logic              req1_ready;
  logic [3:0]        req1_addr;
  logic [LEN_W-1:0]  req1_len;
  logic [DATA_W-1:0] req1_data;

  // Register-file write port
  logic              wEn;
  logic [3:0]        wAddr;
  logic [LEN_W-1:0]  wLen;
  logic [DATA_W-1:0] wData;

  // Issue-stage reservation and hazard tracking
  logic              rsv_en;
  logic [3:0]        rsv_addr;
  logic              flush;
  logic [15:0]       busy;
  logic              err;

  modport master (
    output req0_valid, req0_addr, req0_len, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_len, req1_data,
    input  req1_ready,
    input  wEn, wAddr, wLen, wData,
    output rsv_en, rsv_addr, flush,
    input  busy, err
  );

  modport slave (
    input  req0_valid, req0_addr, req0_len, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_len, req1_data,
    output req1_ready,
    output wEn, wAddr, wLen, wData,
    input  rsv_en, rsv_addr, flush,
    output busy, err
  );
endinterface

// File: rtl/vreg_wb_arbiter.sv
// Write-back arbiter and pending-write scoreboard for the 16-entry vector
// register file. Two producers share one registered write port; the busy
// vector tells the issue stage which registers still have a write in flight.
//
// Build option: define VREG_WB_RR_EN for round-robin tie breaking. Without it
// requester 0 has fixed priority and no arbitration history is kept.
module vreg_wb_arbiter #(
  parameter int DATA_W = 256,
  parameter int LEN_W  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  vreg_wb_arbiter_if.slave bus
);

  // Arbitration results; a grant is only ever given to a valid requester,
  // so a grant is also a completed transfer (the output register is never full).
  logic grant0;
  logic grant1;
  logic xfer;

  // Winner's payload, selected before the output register
  logic [3:0]        sel_addr;
  logic [LEN_W-1:0]  sel_len;
  logic [DATA_W-1:0] sel_data;

  // Write-port register
  logic              wen_reg;
  logic [3:0]        waddr_reg;
  logic [LEN_W-1:0]  wlen_reg;
  logic [DATA_W-1:0] wdata_reg;

  // Scoreboard state
  logic [15:0] busy_reg;
  logic [15:0] busy_next;
  logic [15:0] rsv_hit;
  logic [15:0] wr_hit;
  logic        err_reg;
  logic        err_next;
  logic        rsv_conflict;
  logic        wr_orphan;

`ifdef VREG_WB_RR_EN
  // 1 = requester 1 made the most recent transfer. Resets to 1 so that
  // requester 0 wins the very first tie.
  logic last_reg;

  // Round-robin grant: single requester wins outright, a tie goes to the
  // requester that did not make the most recent transfer.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (bus.req0_valid && !bus.req1_valid) begin
      grant0 = 1'b1;
    end else if (bus.req1_valid && !bus.req0_valid) begin
      grant1 = 1'b1;
    end else if (bus.req0_valid && bus.req1_valid) begin
      if (last_reg) begin
        grant0 = 1'b1;
      end else begin
        grant1 = 1'b1;
      end
    end
  end

  // Remember who transferred last; idle cycles leave the history untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_reg <= 1'b1;
    end else if (xfer) begin
      last_reg <= grant1;
    end
  end
`else
  // Fixed priority grant: requester 0 always wins a tie.
  always_comb begin
    grant0 = bus.req0_valid;
    grant1 = bus.req1_valid && !bus.req0_valid;
  end
`endif

  assign xfer = grant0 | grant1;

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  // Steer the winner's payload toward the write-port register.
  always_comb begin
    sel_addr = bus.req1_addr;
    sel_len  = bus.req1_len;
    sel_data = bus.req1_data;
    if (grant0) begin
      sel_addr = bus.req0_addr;
      sel_len  = bus.req0_len;
      sel_data = bus.req0_data;
    end
  end

  // Write-port register: wEn pulses for one cycle per transfer; address,
  // length and data hold their last values while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_reg   <= 1'b0;
      waddr_reg <= '0;
      wlen_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      wen_reg <= xfer;
      if (xfer) begin
        waddr_reg <= sel_addr;
        wlen_reg  <= sel_len;
        wdata_reg <= sel_data;
      end
    end
  end

  assign bus.wEn   = wen_reg;
  assign bus.wAddr = waddr_reg;
  assign bus.wLen  = wlen_reg;
  assign bus.wData = wdata_reg;

  // Per-register next busy state. Priority: flush clears everything, then a
  // new reservation, then the retiring write, otherwise hold. A reservation
  // landing on the register being written therefore stays pending.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_sb
      assign rsv_hit[gi]   = bus.rsv_en && (bus.rsv_addr == 4'(gi));
      assign wr_hit[gi]    = wen_reg && (waddr_reg == 4'(gi));
      assign busy_next[gi] = bus.flush   ? 1'b0 :
                             rsv_hit[gi] ? 1'b1 :
                             wr_hit[gi]  ? 1'b0 :
                             busy_reg[gi];
    end
  endgenerate

  // Protocol checks: reserving a register that is still pending (and not
  // retiring this cycle), or writing a register nobody reserved.
  always_comb begin
    rsv_conflict = bus.rsv_en && busy_reg[bus.rsv_addr] && !wr_hit[bus.rsv_addr];
    wr_orphan    = wen_reg && !busy_reg[waddr_reg];
    err_next     = err_reg | rsv_conflict | wr_orphan;
  end

  // Scoreboard and sticky error register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      busy_reg <= busy_next;
      err_reg  <= err_next;
    end
  end

  assign bus.busy = busy_reg;
  assign bus.err  = err_reg;

endmodule
